// File: rtl/uart_pkg.sv
// Shared types for the AXIS UART receiver: parity modes, rx FSM states, buffered word.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    PAR_ZERO = 3'd0,
    PAR_ONE  = 3'd1,
    PAR_ODD  = 3'd2,
    PAR_EVEN = 3'd3
  } par_mode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;

  // One buffered frame: error flags {frame_err, parity_err} above the byte.
  typedef struct packed {
    logic [1:0]           user;
    logic [DATA_BITS-1:0] data;
  } rx_word_t;

  // Parity bit the transmitter should have sent; unused mode codes mean constant 0.
  function automatic logic exp_parity(input logic [2:0] mode, input logic [DATA_BITS-1:0] d);
    logic p;
    p = 1'b0;
    case (mode)
      PAR_ONE:  p = 1'b1;
      PAR_ODD:  p = ~^d;
      PAR_EVEN: p = ^d;
      default:  p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO holding received frames, occupancy counter with full/empty flags.
// Latency: a push is visible at the head on the next cycle when the FIFO was empty.
// Backpressure: push is refused when full unless a pop happens in the same cycle.
module uart_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_dat,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head_dat,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty    = (r_count == '0);
  assign o_full     = (r_count == (AW+1)'(DEPTH));
  assign w_do_pop   = i_pop && !o_empty;
  assign w_do_push  = i_push && (!o_full || w_do_pop);
  // Drive zero while empty so the output bus reads as cleared after reset.
  assign o_head_dat = o_empty ? '0 : r_mem[r_rd_ptr];

  // Storage array, written on every accepted push.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_dat;
    end
  end

  // Pointers and occupancy count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/axis_uart_rx.sv
// UART receiver (start, 8 data LSB first, parity, 1/2 stop) to AXI-Stream with error flags in tuser.
// Latency: tvalid rises the cycle after the last stop-bit sample when the output buffer was empty.
// Backpressure: frames buffer while tready=0; a frame arriving to a full buffer is dropped and overrun_o pulses.
// Build option: define UART_RX_FIFO_EN for a FIFO_DEPTH-entry buffer instead of a single holding register.
module axis_uart_rx
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rx,
  output logic [7:0]  maxis_data_o,
  output logic        maxis_tvalid_o,
  input  logic        maxis_tready_i,
  output logic [1:0]  maxis_tuser_o,
  output logic        overrun_o,
  input  logic [31:0] delitel,
  input  logic        stop_bit_num,
  input  logic [2:0]  parity_bit_mode
);

  localparam int SYNC_N   = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  // An illegal buffer depth leaves the receiver idle rather than misbehaving.
  localparam bit DEPTH_OK = (FIFO_DEPTH >= 2) && ((FIFO_DEPTH & (FIFO_DEPTH - 1)) == 0);

  logic [SYNC_N-1:0]    r_sync;
  logic                 r_rx_prev;
  rx_state_t            r_state;
  rx_state_t            w_state_nxt;
  logic [31:0]          r_cnt;
  logic [31:0]          r_div;
  logic                 r_stop_left;
  logic [2:0]           r_mode;
  logic [2:0]           r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_err;
  logic                 r_frame_err;
  logic                 r_overrun;

  logic     w_rx_s, w_fall, w_tick, w_half;
  logic     w_latch, w_cnt_clr, w_shift, w_par_smp, w_stop_smp, w_push, w_pop;
  logic     w_buf_full, w_buf_empty;
  rx_word_t w_push_word, w_head;

  assign w_rx_s = r_sync[SYNC_N-1];
  assign w_fall = DEPTH_OK && r_rx_prev && !w_rx_s;
  assign w_tick = (r_cnt == r_div);
  assign w_half = (r_cnt == (r_div >> 1));

  // Final stop sample is folded in directly because the push happens in the same cycle.
  assign w_push_word.data = r_shift;
  assign w_push_word.user = {r_frame_err | ~w_rx_s, r_par_err};

  // Input synchronizer plus previous-value flop for start-edge detection; idles high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync    <= '1;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync    <= {r_sync[SYNC_N-2:0], uart_rx};
      r_rx_prev <= w_rx_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and per-cycle datapath strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_cnt_clr   = 1'b0;
    w_shift     = 1'b0;
    w_par_smp   = 1'b0;
    w_stop_smp  = 1'b0;
    w_push      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_fall) begin
          w_latch     = 1'b1;
          w_cnt_clr   = 1'b1;
          w_state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (w_half) begin
          w_cnt_clr   = 1'b1;
          w_state_nxt = w_rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          w_cnt_clr = 1'b1;
          w_shift   = 1'b1;
          if (r_bit_idx == 3'(DATA_BITS - 1)) w_state_nxt = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (w_tick) begin
          w_cnt_clr   = 1'b1;
          w_par_smp   = 1'b1;
          w_state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (w_tick) begin
          w_cnt_clr  = 1'b1;
          w_stop_smp = 1'b1;
          if (!r_stop_left) begin
            w_push      = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Bit-period counter, latched frame configuration and received-byte assembly.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_div       <= 32'd3;
      r_stop_left <= 1'b0;
      r_mode      <= 3'd0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_par_err   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_cnt_clr || r_state == ST_IDLE) r_cnt <= '0;
      else                                 r_cnt <= r_cnt + 32'd1;
      if (w_latch) begin
        r_div       <= (delitel < 32'd3) ? 32'd3 : delitel;
        r_stop_left <= stop_bit_num;
        r_mode      <= parity_bit_mode;
        r_bit_idx   <= '0;
        r_par_err   <= 1'b0;
        r_frame_err <= 1'b0;
      end
      if (w_shift) begin
        r_shift   <= {w_rx_s, r_shift[DATA_BITS-1:1]};
        r_bit_idx <= r_bit_idx + 3'd1;
      end
      if (w_par_smp) r_par_err <= (w_rx_s != exp_parity(r_mode, r_shift));
      if (w_stop_smp) begin
        r_stop_left <= 1'b0;
        if (!w_rx_s) r_frame_err <= 1'b1;
      end
    end
  end

  assign w_pop = maxis_tvalid_o && maxis_tready_i;

`ifdef UART_RX_FIFO_EN
  uart_rx_fifo #(
    .WIDTH ($bits(rx_word_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_push     (w_push),
    .i_push_dat (w_push_word),
    .i_pop      (w_pop),
    .o_head_dat (w_head),
    .o_full     (w_buf_full),
    .o_empty    (w_buf_empty)
  );
`else
  logic     r_hold_vld;
  rx_word_t r_hold;

  // Single-entry holding register; a pop in the push cycle frees it for the new frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_vld <= 1'b0;
      r_hold     <= '0;
    end else if (w_push && (!r_hold_vld || w_pop)) begin
      r_hold_vld <= 1'b1;
      r_hold     <= w_push_word;
    end else if (w_pop) begin
      r_hold_vld <= 1'b0;
    end
  end

  assign w_buf_full  = r_hold_vld;
  assign w_buf_empty = !r_hold_vld;
  assign w_head      = r_hold;
`endif

  // Dropped-frame pulse: buffer full and no pop to make room this cycle.
  always_ff @(posedge clk) begin
    if (rst) r_overrun <= 1'b0;
    else     r_overrun <= w_push && w_buf_full && !w_pop;
  end

  assign maxis_tvalid_o = !w_buf_empty;
  assign maxis_data_o   = w_head.data;
  assign maxis_tuser_o  = w_head.user;
  assign overrun_o      = r_overrun;

endmodule
